// File: rtl/shift_reg_ctrl_pkg.sv
// rtl/shift_reg_ctrl_pkg.sv - shared state encoding and bit-order constants for shift_reg_ctrl
package shift_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAR   = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int ORDER_MSB_FIRST = 0;
  localparam int ORDER_LSB_FIRST = 1;

endpackage

// File: rtl/shift_reg_core.sv
// rtl/shift_reg_core.sv - loadable zero-fill shift register with serial output
module shift_reg_core
  import shift_reg_ctrl_pkg::*;
#(
  parameter int W         = 8,
  parameter int LSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic         clk,
  input  logic         r,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (r) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      if (LSB_FIRST == ORDER_LSB_FIRST) q <= {1'b0, q[W-1:1]};
      else                              q <= {q[W-2:0], 1'b0};
    end
  end

  assign sout = (LSB_FIRST == ORDER_LSB_FIRST) ? q[0] : q[W-1];

endmodule

// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - parallel-to-serial transmit controller with stall and done pulse
// Optional trailing even-parity bit when SHIFT_REG_CTRL_PARITY_EN is defined.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int  W         = 8,
  parameter int  LSB_FIRST = ORDER_MSB_FIRST,
  localparam int CW        = $clog2(W)
) (
  input  logic         clk,
  input  logic         r,
  input  logic         start,
  input  logic [W-1:0] din,
  input  logic         stall,
  output logic         ready,
  output logic         busy,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift_en;
  logic          core_sout;
  logic          par_bit;

  assign load     = (state == IDLE) && start;
  assign shift_en = (state == SHIFT) && !stall;

  always_ff @(posedge clk) begin
    if (r) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= CW'(W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!stall) begin
            if (cnt == '0) begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
              state <= PAR;
`else
              state <= DONE;
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
`ifdef SHIFT_REG_CTRL_PARITY_EN
        PAR:     if (!stall) state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_REG_CTRL_PARITY_EN
  // Parity is captured from din at load, independent of what the shifter holds later.
  logic par_q;
  always_ff @(posedge clk) begin
    if (r)         par_q <= 1'b0;
    else if (load) par_q <= ^din;
  end
  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  shift_reg_core #(.W(W), .LSB_FIRST(LSB_FIRST)) u_core (
    .clk      (clk),
    .r        (r),
    .load     (load),
    .shift_en (shift_en),
    .din      (din),
    .sout     (core_sout)
  );

  assign ready      = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign sout_valid = ((state == SHIFT) || (state == PAR)) && !stall;
  assign sout       = (state == SHIFT) ? core_sout :
                      (state == PAR)   ? par_bit   : 1'b0;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - self-checking bench for shift_reg_ctrl, MSB-first and LSB-first instances
module tb_shift_reg_ctrl;

  localparam int W = 8;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic         stall = 1'b0;

  logic ready_m, busy_m, sout_m, sv_m, done_m;
  logic ready_l, busy_l, sout_l, sv_l, done_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.W(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .r(r), .start(start), .din(din), .stall(stall),
    .ready(ready_m), .busy(busy_m), .sout(sout_m), .sout_valid(sv_m), .done(done_m)
  );

  shift_reg_ctrl #(.W(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .r(r), .start(start), .din(din), .stall(stall),
    .ready(ready_l), .busy(busy_l), .sout(sout_l), .sout_valid(sv_l), .done(done_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 transmitting, 2 done; queues hold the bits still to be sent.
  int ph = 0;
  bit qm[$];
  bit ql[$];

  always @(posedge clk) begin
    if (r) begin
      ph = 0;
      qm.delete();
      ql.delete();
    end else begin
      case (ph)
        0: if (start) begin
          for (int i = W - 1; i >= 0; i--) qm.push_back(din[i]);
          for (int i = 0; i < W; i++)      ql.push_back(din[i]);
          if (PB == 1) begin
            qm.push_back(^din);
            ql.push_back(^din);
          end
          ph = 1;
        end
        1: if (!stall) begin
          void'(qm.pop_front());
          void'(ql.pop_front());
          if (qm.size() == 0) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", ready_m, ph == 0);
      chk("m_busy",  busy_m,  ph != 0);
      chk("m_done",  done_m,  ph == 2);
      chk("m_valid", sv_m,    (ph == 1) && !stall);
      chk("m_sout",  sout_m,  (ph == 1) ? qm[0] : 1'b0);
      chk("l_ready", ready_l, ph == 0);
      chk("l_busy",  busy_l,  ph != 0);
      chk("l_done",  done_l,  ph == 2);
      chk("l_valid", sv_l,    (ph == 1) && !stall);
      chk("l_sout",  sout_l,  (ph == 1) ? ql[0] : 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] with_par(input logic [15:0] v, input bit p);
    return (PB == 1) ? {v[14:0], p} : v;
  endfunction

  // Starts a transfer and returns the done cycle (relative to acceptance) and captured streams.
  task automatic run_xfer(input logic [W-1:0] d, input int sf, input int sn, input int bs,
                          output int done_cyc, output logic [15:0] cm, output logic [15:0] cl);
    int cyc;
    cm = '0;
    cl = '0;
    done_cyc = -1;
    din = d;
    start = 1'b1;
    step();
    cyc = 1;
    while (cyc < 40) begin
      stall = (cyc >= sf) && (cyc < sf + sn);
      if (cyc == bs) begin
        start = 1'b1;
        din = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (sv_m) cm = {cm[14:0], sout_m};
      if (sv_l) cl = {cl[14:0], sout_l};
      if (done_m) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;
    if (done_cyc < 0) chk("timeout", 32'd0, 32'd1);
    step();
    @(negedge clk);
    chk("ready_after_done", ready_m, 1'b1);
    step();
  endtask

  int          dc;
  logic [15:0] cm, cl;

  initial begin
    r = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", ready_m, 1'b1);
      chk("idle_busy",  busy_m,  1'b0);
      chk("idle_valid", sv_m,    1'b0);
      chk("idle_done",  done_m,  1'b0);
      step();
    end

    run_xfer(8'hA5, 99, 0, 0, dc, cm, cl);
    chk("a5_done_cyc", dc, W + 1 + PB);
    chk("a5_msb", cm, with_par(16'h00A5, 1'b0));
    chk("a5_lsb", cl, with_par(16'h00A5, 1'b0));

    run_xfer(8'h01, 99, 0, 0, dc, cm, cl);
    chk("01_msb", cm, with_par(16'h0001, 1'b1));
    chk("01_lsb", cl, with_par(16'h0080, 1'b1));

    run_xfer(8'h3C, 3, 3, 2, dc, cm, cl);
    chk("3c_done_cyc", dc, 12 + PB);
    chk("3c_msb", cm, with_par(16'h003C, 1'b0));
    chk("3c_lsb", cl, with_par(16'h003C, 1'b0));

    din = 8'h5A;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    r = 1'b1;
    step();
    r = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready_m, 1'b1);
    chk("rst_sout",  sout_m,  1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_no_done", done_m, 1'b0);
      step();
    end
    run_xfer(8'hFF, 99, 0, 0, dc, cm, cl);
    chk("ff_done_cyc", dc, W + 1 + PB);
    chk("ff_msb", cm, with_par(16'h00FF, 1'b0));

`ifdef SHIFT_REG_CTRL_PARITY_EN
    run_xfer(8'h07, 99, 0, 0, dc, cm, cl);
    chk("07_done_cyc", dc, 10);
    chk("07_msb", cm, 16'h000F);
    run_xfer(8'h03, 99, 0, 0, dc, cm, cl);
    chk("03_msb", cm, 16'h0006);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
